// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared register-file geometry and writeback types
package regfile_ctrl_pkg;

  localparam int NUM_REGS      = 32;
  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 32;
  localparam int CNT_W_DEFAULT = 2;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant, pointer moves on grant
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] last_d;
  logic [NREQ-1:0]  gnt;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    int cand;
    cand   = 0;
    gnt    = '0;
    last_d = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if ((gnt == '0) && req_i[PTR_W'(cand)]) begin
        gnt[PTR_W'(cand)] = 1'b1;
        last_d            = PTR_W'(cand);
      end
    end
  end

  assign gnt_o = rst_ni ? gnt : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PTR_W'(NREQ - 1);
    end else if (|gnt) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with per-register write scoreboard
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ok,
  output logic [NUM_REGS-1:0]    busy,
  output logic [ADDR_W-1:0]      RW,
  output logic [DATA_W-1:0]      PW_DS,
  output logic                   E,
  output logic                   wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_req_t          sel;
  logic             xfer;
  logic             e_q, e_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] pw_q, pw_d;
  logic             wb_err_q, wb_err_d;
  logic             rsv_take;
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .req_i  (req_valid),
    .gnt_o  (req_ready)
  );

  assign xfer = |req_ready;

  // Grant is one-hot, so an OR-mux of the selected slices is sufficient.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel.addr = req_addr[i*ADDR_W +: ADDR_W];
        sel.data = req_data[i*DATA_W +: DATA_W];
      end
    end
    sel.we = (sel.addr != ZERO_REG);
  end

  always_comb begin
    e_d  = xfer && sel.we;
    rw_d = rw_q;
    pw_d = pw_q;
    if (xfer) begin
      rw_d = sel.addr;
      pw_d = sel.data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      e_q  <= 1'b0;
      rw_q <= '0;
      pw_q <= '0;
    end else begin
      e_q  <= e_d;
      rw_q <= rw_d;
      pw_q <= pw_d;
    end
  end

  assign E     = e_q;
  assign RW    = rw_q;
  assign PW_DS = pw_q;

  assign rsv_ok   = rsv_valid && ((rsv_addr == ZERO_REG) || (cnt_q[rsv_addr] != CNT_MAX));
  assign rsv_take = rsv_ok && (rsv_addr != ZERO_REG);

  // A reserve and a commit to the same register cancel out; a commit never underflows.
  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      inc = rsv_take && (rsv_addr == ADDR_W'(r));
      dec = e_q && (rw_q == ADDR_W'(r));
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    cnt_d[0] = '0;
  end

  assign wb_err_d = wb_err_q || (e_q && (cnt_q[rw_q] == '0));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      wb_err_q <= wb_err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign wb_err = wb_err_q;

endmodule
